// File: rtl/dag_arb.sv
// Arbiter in front of the data address generator: core single-cycle requests
// share the generator with a post-modify burst walker; all outputs registered.
module dag_arb #(
   parameter int LENW    = 8,
   parameter int MAXWAIT = 4
) (
   input  logic            clk_rf,
   input  logic            rst_n,
   input  logic            cr_req,
   input  logic            cr_dgsclt,
   input  logic [2:0]      cr_iadd,
   input  logic [2:0]      cr_madd,
   input  logic            cr_mdfy,
   output logic            cr_gnt,
   output logic            cr_stall,
   input  logic            br_start,
   input  logic            br_abort,
   input  logic            br_dgsclt,
   input  logic [2:0]      br_iadd,
   input  logic [2:0]      br_madd,
   input  logic [LENW-1:0] br_len,
   output logic            br_busy,
   output logic            br_beat,
   output logic            br_done,
   output logic            br_err,
   input  logic            ps_dg_wrt_en,
   input  logic [4:0]      ps_dg_wrt_add,
   output logic            dg_en,
   output logic            dg_dgsclt,
   output logic [2:0]      dg_iadd,
   output logic [2:0]      dg_madd,
   output logic            dg_mdfy,
   output logic            dg_owner
);

   typedef enum logic {IDLE, RUN} state_e;

   localparam logic [3:0] MAXW = 4'(MAXWAIT);

   state_e          state_q, state_d;
   logic [LENW-1:0] rem_q, rem_d;
   logic [3:0]      wait_q, wait_d;
   logic            bsc_q, bsc_d;
   logic [2:0]      bi_q, bi_d, bm_q, bm_d;

   logic            en_q, en_d, sc_q, sc_d, md_q, md_d, own_q, own_d;
   logic [2:0]      ia_q, ia_d, ma_q, ma_d;
   logic            gnt_q, gnt_d, stall_q, stall_d;
   logic            busy_q, busy_d, beat_q, beat_d, done_q, done_d, err_q, err_d;

   logic            coreSlot, beatSlot, hazard;

   // A write to the burst's own I or M register in this cycle makes the beat unsafe.
   assign hazard = ps_dg_wrt_en &
                   ((ps_dg_wrt_add == {1'b1, bsc_q, bi_q}) |
                    (ps_dg_wrt_add == {1'b0, bsc_q, bm_q}));

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      wait_d   = wait_q;
      bsc_d    = bsc_q;
      bi_d     = bi_q;
      bm_d     = bm_q;
      coreSlot = 1'b0;
      beatSlot = 1'b0;
      stall_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      en_d     = 1'b0;
      sc_d     = 1'b0;
      ia_d     = 3'd0;
      ma_d     = 3'd0;
      md_d     = 1'b0;
      own_d    = 1'b0;
      gnt_d    = 1'b0;
      beat_d   = 1'b0;

      case (state_q)
         IDLE: begin
            coreSlot = cr_req;
            if (br_start) begin
               if (br_len != '0) begin
                  bsc_d   = br_dgsclt;
                  bi_d    = br_iadd;
                  bm_d    = br_madd;
                  rem_d   = br_len;
                  wait_d  = 4'd0;
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Priority: abort, hazard, forced slot, core, burst.
            if (br_abort) begin
               coreSlot = cr_req;
               rem_d    = '0;
               wait_d   = 4'd0;
               state_d  = IDLE;
            end else if (hazard) begin
               coreSlot = cr_req;
               if (wait_q != MAXW) wait_d = wait_q + 4'd1;
            end else if (wait_q == MAXW) begin
               beatSlot = 1'b1;
               stall_d  = cr_req;
            end else if (cr_req) begin
               coreSlot = 1'b1;
               wait_d   = wait_q + 4'd1;
            end else begin
               beatSlot = 1'b1;
            end

            if (beatSlot) begin
               rem_d  = rem_q - 1'b1;
               wait_d = 4'd0;
               if (rem_q == LENW'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (coreSlot) begin
         en_d  = 1'b1;
         sc_d  = cr_dgsclt;
         ia_d  = cr_iadd;
         ma_d  = cr_madd;
         md_d  = cr_mdfy;
         gnt_d = 1'b1;
      end else if (beatSlot) begin
         en_d   = 1'b1;
         sc_d   = bsc_q;
         ia_d   = bi_q;
         ma_d   = bm_q;
         md_d   = 1'b1;
         own_d  = 1'b1;
         beat_d = 1'b1;
      end

      busy_d = (state_d == RUN) | done_d;
   end

   always_ff @(posedge clk_rf or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         wait_q  <= 4'd0;
         bsc_q   <= 1'b0;
         bi_q    <= 3'd0;
         bm_q    <= 3'd0;
         en_q    <= 1'b0;
         sc_q    <= 1'b0;
         ia_q    <= 3'd0;
         ma_q    <= 3'd0;
         md_q    <= 1'b0;
         own_q   <= 1'b0;
         gnt_q   <= 1'b0;
         stall_q <= 1'b0;
         busy_q  <= 1'b0;
         beat_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         wait_q  <= wait_d;
         bsc_q   <= bsc_d;
         bi_q    <= bi_d;
         bm_q    <= bm_d;
         en_q    <= en_d;
         sc_q    <= sc_d;
         ia_q    <= ia_d;
         ma_q    <= ma_d;
         md_q    <= md_d;
         own_q   <= own_d;
         gnt_q   <= gnt_d;
         stall_q <= stall_d;
         busy_q  <= busy_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign dg_en     = en_q;
   assign dg_dgsclt = sc_q;
   assign dg_iadd   = ia_q;
   assign dg_madd   = ma_q;
   assign dg_mdfy   = md_q;
   assign dg_owner  = own_q;
   assign cr_gnt    = gnt_q;
   assign cr_stall  = stall_q;
   assign br_busy   = busy_q;
   assign br_beat   = beat_q;
   assign br_done   = done_q;
   assign br_err    = err_q;

endmodule

// File: tb/tb_dag_arb.sv
// Scoreboard bench for dag_arb: each scenario queues per-cycle stimulus and the
// hand-derived registered output vector expected after that clock edge.
module tb_dag_arb;

   logic       clk_rf = 1'b0;
   logic       rst_n;
   logic       cr_req, cr_dgsclt, cr_mdfy;
   logic [2:0] cr_iadd, cr_madd;
   logic       cr_gnt, cr_stall;
   logic       br_start, br_abort, br_dgsclt;
   logic [2:0] br_iadd, br_madd;
   logic [7:0] br_len;
   logic       br_busy, br_beat, br_done, br_err;
   logic       ps_dg_wrt_en;
   logic [4:0] ps_dg_wrt_add;
   logic       dg_en, dg_dgsclt, dg_mdfy, dg_owner;
   logic [2:0] dg_iadd, dg_madd;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       req, sc, md, start, abort, bsc, wen;
      logic [2:0] ci, cm, bi, bm;
      logic [7:0] len;
      logic [4:0] wadd;
   } stim_t;

   stim_t       stimQ[$];
   logic [15:0] sb[$];

   always #5 clk_rf = ~clk_rf;

   dag_arb #(.LENW(8), .MAXWAIT(4)) dut (
      .clk_rf(clk_rf), .rst_n(rst_n),
      .cr_req(cr_req), .cr_dgsclt(cr_dgsclt), .cr_iadd(cr_iadd), .cr_madd(cr_madd),
      .cr_mdfy(cr_mdfy), .cr_gnt(cr_gnt), .cr_stall(cr_stall),
      .br_start(br_start), .br_abort(br_abort), .br_dgsclt(br_dgsclt),
      .br_iadd(br_iadd), .br_madd(br_madd), .br_len(br_len),
      .br_busy(br_busy), .br_beat(br_beat), .br_done(br_done), .br_err(br_err),
      .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
      .dg_en(dg_en), .dg_dgsclt(dg_dgsclt), .dg_iadd(dg_iadd), .dg_madd(dg_madd),
      .dg_mdfy(dg_mdfy), .dg_owner(dg_owner)
   );

   // Output vector: {en,sc,iadd,madd,mdfy,owner,gnt,stall,busy,beat,done,err}
   function automatic logic [15:0] obsV();
      return {dg_en, dg_dgsclt, dg_iadd, dg_madd, dg_mdfy, dg_owner,
              cr_gnt, cr_stall, br_busy, br_beat, br_done, br_err};
   endfunction

   function automatic logic [15:0] eIdle(input logic busy);
      return {12'd0, busy, 3'b000};
   endfunction

   function automatic logic [15:0] eCore(input logic sc, input logic [2:0] i,
                                         input logic [2:0] m, input logic md,
                                         input logic busy);
      return {1'b1, sc, i, m, md, 1'b0, 1'b1, 1'b0, busy, 3'b000};
   endfunction

   function automatic logic [15:0] eBeat(input logic sc, input logic [2:0] i,
                                         input logic [2:0] m, input logic stall,
                                         input logic done);
      return {1'b1, sc, i, m, 1'b1, 1'b1, 1'b0, stall, 1'b1, 1'b1, done, 1'b0};
   endfunction

   function automatic stim_t sNone();
      stim_t s;
      s.req = 0; s.sc = 0; s.md = 0; s.start = 0; s.abort = 0; s.bsc = 0; s.wen = 0;
      s.ci = 0; s.cm = 0; s.bi = 0; s.bm = 0; s.len = 0; s.wadd = 0;
      return s;
   endfunction

   function automatic stim_t sCore(input logic sc, input logic [2:0] i,
                                   input logic [2:0] m, input logic md);
      stim_t s = sNone();
      s.req = 1; s.sc = sc; s.ci = i; s.cm = m; s.md = md;
      return s;
   endfunction

   function automatic stim_t sStart(input stim_t base, input logic sc, input logic [2:0] i,
                                    input logic [2:0] m, input logic [7:0] len);
      stim_t s = base;
      s.start = 1; s.bsc = sc; s.bi = i; s.bm = m; s.len = len;
      return s;
   endfunction

   // Applies one cycle of stimulus at the falling edge and returns just after the rising edge.
   task automatic applyStimulus(input stim_t s);
      @(negedge clk_rf);
      cr_req = s.req; cr_dgsclt = s.sc; cr_iadd = s.ci; cr_madd = s.cm; cr_mdfy = s.md;
      br_start = s.start; br_abort = s.abort; br_dgsclt = s.bsc;
      br_iadd = s.bi; br_madd = s.bm; br_len = s.len;
      ps_dg_wrt_en = s.wen; ps_dg_wrt_add = s.wadd;
      @(posedge clk_rf);
      #1;
   endtask

   task automatic push(input stim_t s, input logic [15:0] e);
      stimQ.push_back(s);
      sb.push_back(e);
   endtask

   task automatic test_reset();
      logic [15:0] got;
      applyStimulus(sNone());
      got = obsV();
      checks++;
      if (got !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_hold got=%h exp=%h", got, 16'd0);
      end
      @(negedge clk_rf);
      rst_n = 1'b1;
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL reset_idle cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_basic_burst();
      stim_t s;
      push(sStart(sNone(), 0, 3'd2, 3'd5, 8'd3), eIdle(1));
      push(sNone(), eBeat(0, 3'd2, 3'd5, 0, 0));
      s = sStart(sNone(), 1, 3'd7, 3'd7, 8'd7);
      push(s, eBeat(0, 3'd2, 3'd5, 0, 0));
      push(sNone(), eBeat(0, 3'd2, 3'd5, 0, 1));
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] got, exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL basic_burst cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_starvation();
      stim_t core = sCore(1, 3'd7, 3'd1, 0);
      push(sStart(core, 0, 3'd4, 3'd6, 8'd4), eCore(1, 3'd7, 3'd1, 0, 1));
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 4; k++) push(core, eCore(1, 3'd7, 3'd1, 0, 1));
         push(core, eBeat(0, 3'd4, 3'd6, 1, b == 3));
      end
      push(core, eCore(1, 3'd7, 3'd1, 0, 0));
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] got, exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL starvation cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_hazard();
      stim_t h;
      push(sStart(sNone(), 1, 3'd3, 3'd2, 8'd3), eIdle(1));
      push(sNone(), eBeat(1, 3'd3, 3'd2, 0, 0));
      for (int k = 0; k < 4; k++) push(sCore(0, 3'd1, 3'd4, 1), eCore(0, 3'd1, 3'd4, 1, 1));
      h = sNone(); h.wen = 1; h.wadd = 5'b11011;
      push(h, eIdle(1));
      push(h, eIdle(1));
      h.wadd = 5'b01010;
      push(h, eIdle(1));
      h.wadd = 5'b01011;
      push(h, eBeat(1, 3'd3, 3'd2, 0, 0));
      push(sNone(), eBeat(1, 3'd3, 3'd2, 0, 1));
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] got, exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL hazard cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_zero_len();
      push(sStart(sNone(), 1, 3'd1, 3'd1, 8'd0), 16'h0001);
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] got, exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL zero_len cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_abort();
      stim_t a;
      push(sStart(sNone(), 0, 3'd1, 3'd1, 8'd10), eIdle(1));
      for (int k = 0; k < 3; k++) push(sNone(), eBeat(0, 3'd1, 3'd1, 0, 0));
      a = sCore(1, 3'd5, 3'd3, 1); a.abort = 1;
      push(a, eCore(1, 3'd5, 3'd3, 1, 0));
      push(sStart(sNone(), 1, 3'd6, 3'd0, 8'd2), eIdle(1));
      push(sNone(), eBeat(1, 3'd6, 3'd0, 0, 0));
      push(sNone(), eBeat(1, 3'd6, 3'd0, 0, 1));
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] got, exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL abort cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] got;
      push(sStart(sNone(), 0, 3'd4, 3'd3, 8'd5), eIdle(1));
      push(sNone(), eBeat(0, 3'd4, 3'd3, 0, 0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL async_pre cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      got = obsV();
      checks++;
      if (got !== 16'd0) begin
         failures++;
         $display("[TB] FAIL async_reset got=%h exp=%h", got, 16'd0);
      end
      @(negedge clk_rf);
      rst_n = 1'b1;
      push(sStart(sNone(), 0, 3'd5, 3'd2, 8'd1), eIdle(1));
      push(sNone(), eBeat(0, 3'd5, 3'd2, 0, 1));
      push(sNone(), eIdle(0));
      for (int c = 0; stimQ.size() > 0; c++) begin
         logic [15:0] exp;
         applyStimulus(stimQ.pop_front());
         got = obsV(); exp = sb.pop_front(); checks++;
         if (got !== exp) begin
            failures++;
            $display("[TB] FAIL async_post cyc%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cr_req = 0; cr_dgsclt = 0; cr_iadd = 0; cr_madd = 0; cr_mdfy = 0;
      br_start = 0; br_abort = 0; br_dgsclt = 0; br_iadd = 0; br_madd = 0; br_len = 0;
      ps_dg_wrt_en = 0; ps_dg_wrt_add = 0;
      test_reset();
      test_basic_burst();
      test_starvation();
      test_hazard();
      test_zero_len();
      test_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
